// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin drain of four VC source FIFOs into one destination FIFO; pop-to-write is one cycle.
// No pops while dest_almost_full or !sched_en; grant and remaining credit are held across such stalls.
module vc_wrr_scheduler #(
    parameter int BW  = 6,
    parameter int WW  = 3,
    parameter int NVC = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              sched_en,
    input  logic [NVC*WW-1:0] vc_weight,
    input  logic [NVC-1:0]    vc_empty,
    input  logic [NVC*BW-1:0] vc_data,
    output logic [NVC-1:0]    vc_rd,
    input  logic              dest_almost_full,
    input  logic              dest_full,
    output logic              dest_wr,
    output logic [BW-1:0]     dest_data,
    output logic [1:0]        grant_vc,
    output logic              sched_error
);
    typedef enum logic [1:0] {IDLE, SERVE, ROTATE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    grant_nxt;
    logic [WW-1:0] credit, credit_nxt;
    logic          started, started_nxt;
    logic          wr_pend;
    logic          pop;
    logic [1:0]    search_base;
    logic          found;
    logic [1:0]    found_vc;
    logic [WW-1:0] raw_weight;
    logic [WW-1:0] found_weight;

    // Descending scan so the smallest offset from search_base wins; the granted VC comes last.
    always_comb begin
        found       = 1'b0;
        found_vc    = '0;
        search_base = (state == IDLE && !started) ? 2'd0 : grant_vc + 2'd1;
        for (int i = NVC - 1; i >= 0; i--) begin
            if (!vc_empty[search_base + 2'(i)]) begin
                found    = 1'b1;
                found_vc = search_base + 2'(i);
            end
        end
    end

    assign raw_weight   = vc_weight[32'(found_vc)*WW +: WW];
    assign found_weight = (raw_weight == '0) ? WW'(1) : raw_weight;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_vc;
        credit_nxt  = credit;
        started_nxt = started;
        pop         = 1'b0;
        unique case (state)
            IDLE: begin
                if (sched_en && found) begin
                    grant_nxt   = found_vc;
                    credit_nxt  = found_weight;
                    started_nxt = 1'b1;
                    state_nxt   = SERVE;
                end
            end
            SERVE: begin
                pop = sched_en && !vc_empty[grant_vc] && (credit != '0) && !dest_almost_full;
                if (pop) begin
                    credit_nxt = credit - WW'(1);
                end
                if ((pop && credit == WW'(1)) ||
                    (!pop && (credit == '0 || vc_empty[grant_vc]))) begin
                    state_nxt = ROTATE;
                end
            end
            ROTATE: begin
                if (found) begin
                    grant_nxt  = found_vc;
                    credit_nxt = found_weight;
                    state_nxt  = SERVE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state       <= IDLE;
            grant_vc    <= '0;
            credit      <= '0;
            started     <= 1'b0;
            wr_pend     <= 1'b0;
            sched_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant_vc <= grant_nxt;
            credit   <= credit_nxt;
            started  <= started_nxt;
            wr_pend  <= pop;
            if (wr_pend && dest_full) begin
                sched_error <= 1'b1;
            end
        end
    end

    // grant_vc cannot change between a pop and its write: SERVE only exits via ROTATE,
    // which updates the grant at the end of the write cycle.
    assign vc_rd     = {NVC{pop}} & (NVC'(1) << grant_vc);
    assign dest_wr   = wr_pend;
    assign dest_data = wr_pend ? vc_data[32'(grant_vc)*BW +: BW] : '0;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Bench for vc_wrr_scheduler: behavioural source FIFOs, scoreboard of expected destination writes.
module tb_vc_wrr_scheduler;
    localparam int BW  = 6;
    localparam int WW  = 3;
    localparam int NVC = 4;

    typedef struct {
        logic [BW-1:0] data;
        int            gap;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_L;
    logic              sched_en;
    logic [NVC*WW-1:0] vc_weight;
    logic [NVC-1:0]    vc_empty = '1;
    logic [NVC*BW-1:0] vc_data = '0;
    logic [NVC-1:0]    vc_rd;
    logic              dest_almost_full;
    logic              dest_full;
    logic              dest_wr;
    logic [BW-1:0]     dest_data;
    logic [1:0]        grant_vc;
    logic              sched_error;

    logic [BW-1:0] vc_q[NVC][$];
    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            last_wr = 0;

    vc_wrr_scheduler #(.BW(BW), .WW(WW), .NVC(NVC)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .sched_en         (sched_en),
        .vc_weight        (vc_weight),
        .vc_empty         (vc_empty),
        .vc_data          (vc_data),
        .vc_rd            (vc_rd),
        .dest_almost_full (dest_almost_full),
        .dest_full        (dest_full),
        .dest_wr          (dest_wr),
        .dest_data        (dest_data),
        .grant_vc         (grant_vc),
        .sched_error      (sched_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source FIFOs with one-cycle read latency: pop sampled at the edge, data shown just after it.
    always @(posedge clk) begin : fifo_model
        logic [NVC-1:0] rd;
        rd = vc_rd;
        #1;
        for (int k = 0; k < NVC; k++) begin
            if (rd[k] && vc_q[k].size() != 0) vc_data[k*BW +: BW] = vc_q[k].pop_front();
            vc_empty[k] = (vc_q[k].size() == 0);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_L && dest_wr) begin
            check("wr_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("dest_data", int'(dest_data), int'(e.data));
                check("grant_at_wr", int'(grant_vc), int'(e.data[BW-1 -: 2]));
                if (e.gap != 0) check("wr_gap", cyc - last_wr, e.gap);
            end
            last_wr = cyc;
        end
    end

    task automatic push_exp(input int data, input int gap);
        exp_t e;
        e.data = BW'(data);
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic load(input int vc, input int n);
        for (int i = 1; i <= n; i++) vc_q[vc].push_back(BW'(vc*16 + i));
    endtask

    task automatic do_reset();
        sched_en         = 1'b0;
        dest_almost_full = 1'b0;
        dest_full        = 1'b0;
        reset_L          = 1'b0;
        for (int k = 0; k < NVC; k++) vc_q[k].delete();
        sb.delete();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Expected order for weights {3,1,0->1,0->1} with 8 words per VC; a turn cut short by an
    // empty FIFO costs one extra cycle before the rotate bubble.
    task automatic gen_weighted(output int last_vc);
        int cnt[4];
        int nxt[4];
        int w[4];
        int cur;
        int gap;
        int left;
        int n;
        w = '{3, 1, 1, 1};
        cnt = '{8, 8, 8, 8};
        nxt = '{1, 1, 1, 1};
        cur = 0;
        gap = 0;
        left = 32;
        last_vc = 0;
        while (left > 0) begin
            if (cnt[cur] > 0) begin
                n = (cnt[cur] < w[cur]) ? cnt[cur] : w[cur];
                for (int j = 0; j < n; j++) begin
                    push_exp(cur*16 + nxt[cur], (j == 0) ? gap : 1);
                    nxt[cur]++;
                    cnt[cur]--;
                    left--;
                end
                gap = (n < w[cur]) ? 3 : 2;
                last_vc = cur;
            end
            cur = (cur + 1) % 4;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int pops;
        int last_vc;
        reset_L          = 1'b0;
        sched_en         = 1'b0;
        vc_weight        = {4{3'd1}};
        dest_almost_full = 1'b0;
        dest_full        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vc_rd", int'(vc_rd), 0);
        check("rst_dest_wr", int'(dest_wr), 0);
        check("rst_dest_data", int'(dest_data), 0);
        check("rst_grant", int'(grant_vc), 0);
        check("rst_error", int'(sched_error), 0);

        // Reset arriving while a pop is on the wire.
        reset_L = 1'b1;
        load(0, 2);
        @(negedge clk);
        sched_en = 1'b1;
        t = 0;
        while (!vc_rd[0] && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("midpop_seen", int'(vc_rd[0]), 1);
        #2 reset_L = 1'b0;
        #1;
        check("midpop_vc_rd", int'(vc_rd), 0);
        check("midpop_dest_wr", int'(dest_wr), 0);
        check("midpop_dest_data", int'(dest_data), 0);
        check("midpop_grant", int'(grant_vc), 0);
        check("midpop_error", int'(sched_error), 0);
        @(posedge clk);
        #1;
        check("midpop_no_wr", int'(dest_wr), 0);

        // Equal weights, two words per VC.
        do_reset();
        vc_weight = {4{3'd1}};
        for (int i = 1; i <= 2; i++)
            for (int k = 0; k < NVC; k++) push_exp(k*16 + i, (i == 1 && k == 0) ? 0 : 2);
        for (int k = 0; k < NVC; k++) load(k, 2);
        @(negedge clk);
        sched_en = 1'b1;
        wait_drain("eq_drain", 60);
        repeat (3) @(negedge clk);
        check("eq_idle_grant", int'(grant_vc), 3);
        check("eq_idle_rd", int'(vc_rd), 0);

        // Weighted 3/1/0/0, eight words per VC.
        do_reset();
        vc_weight = {3'd0, 3'd0, 3'd1, 3'd3};
        for (int k = 0; k < NVC; k++) load(k, 8);
        gen_weighted(last_vc);
        @(negedge clk);
        sched_en = 1'b1;
        wait_drain("wrr_drain", 150);
        repeat (3) @(negedge clk);
        check("wrr_idle_grant", int'(grant_vc), last_vc);

        // Backpressure for 5 cycles after two of four credits are spent.
        do_reset();
        vc_weight = {3'd1, 3'd1, 3'd1, 3'd4};
        load(0, 6);
        for (int i = 1; i <= 6; i++) push_exp(i, 0);
        @(negedge clk);
        sched_en = 1'b1;
        t = 0;
        pops = 0;
        while (pops < 2 && t < 20) begin
            @(negedge clk);
            if (vc_rd[0]) pops++;
            t++;
        end
        check("bp_two_pops", pops, 2);
        @(posedge clk);
        #1 dest_almost_full = 1'b1;
        @(negedge clk);
        check("bp_stall_rd", int'(vc_rd), 0);
        check("bp_pending_wr", int'(dest_wr), 1);
        repeat (4) begin
            @(negedge clk);
            check("bp_stall_rd", int'(vc_rd), 0);
        end
        @(posedge clk);
        #1 dest_almost_full = 1'b0;
        @(negedge clk);
        check("bp_resume_1", int'(vc_rd), 1);
        @(negedge clk);
        check("bp_resume_2", int'(vc_rd), 1);
        @(negedge clk);
        check("bp_rotate_bubble", int'(vc_rd), 0);
        @(negedge clk);
        check("bp_regrant", int'(vc_rd), 1);
        wait_drain("bp_drain", 30);

        // Empty skip and wrap 3 -> 1.
        do_reset();
        vc_weight = {4{3'd1}};
        load(3, 1);
        push_exp(8'h31, 0);
        push_exp(8'h11, 2);
        @(negedge clk);
        sched_en = 1'b1;
        t = 0;
        while (!vc_rd[3] && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("wrap_first_grant", int'(grant_vc), 3);
        load(1, 1);
        wait_drain("wrap_drain", 20);
        repeat (3) @(negedge clk);
        check("wrap_idle_grant", int'(grant_vc), 1);
        check("wrap_idle_rd", int'(vc_rd), 0);

        // Write landing on a full destination.
        do_reset();
        check("ovf_clear", int'(sched_error), 0);
        vc_weight = {4{3'd1}};
        load(0, 1);
        push_exp(1, 0);
        dest_full        = 1'b1;
        dest_almost_full = 1'b0;
        @(negedge clk);
        sched_en = 1'b1;
        wait_drain("ovf_drain", 10);
        @(negedge clk);
        check("ovf_set", int'(sched_error), 1);
        dest_full = 1'b0;
        repeat (4) @(negedge clk);
        check("ovf_sticky", int'(sched_error), 1);
        reset_L = 1'b0;
        #1;
        check("ovf_reset", int'(sched_error), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vc_wrr_scheduler.md
Name: vc_wrr_scheduler

Overview:
- Weighted round-robin scheduler that drains four virtual-channel source FIFOs into one shared destination FIFO of the PCIe QoS interconnect.
- It issues pops to the source FIFOs and forwards the returned data to the destination as one-cycle write strobes.
- It respects destination backpressure (almost_full) and per-VC programmable weights.
- It sits between the VC FIFO bank and a destination FIFO (D0/D1).

Parameters:
- BW, 6, data width of every FIFO word.
- WW, 3, width of each per-VC weight field.
- NVC, 4, number of virtual channels; fixed at 4; other values unsupported.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_L  input  1  asynchronous active-low reset.
- sched_en  input  1  scheduler enable; when 0 no new pops are issued.
- vc_weight  input  4*WW  per-VC weight, VCk in bits [k*WW +: WW]; sampled on each credit reload.
- vc_empty  input  4  source FIFO empty flags, bit k = VCk.
- vc_data  input  4*BW  source FIFO read data, VCk in [k*BW +: BW].
- vc_rd  output  4  one-hot pop strobes to source FIFOs.
- dest_almost_full  input  1  destination almost-full flag.
- dest_full  input  1  destination full flag.
- dest_wr  output  1  destination write strobe.
- dest_data  output  BW  destination write data.
- grant_vc  output  2  VC currently holding the grant.
- sched_error  output  1  sticky: write issued while dest_full.

Behaviour:
- Source FIFO read latency:
  - vc_data for VCk is valid the cycle after vc_rd[k].
  - Cycle N: vc_rd[k]=1. Cycle N+1: dest_wr=1, dest_data = vc_data[k] registered in N+1 (combinational pass-through of that slice, gated by the write-pending flop).
- Reset (async, reset_L=0):
  - vc_rd=0, dest_wr=0, dest_data=0, grant_vc=0, sched_error=0.
  - credit=0, state=IDLE, write-pending flop cleared.
  - An in-flight pop is dropped; the source FIFO has already advanced, which is accepted.
- Effective weight: w_eff = (vc_weight field == 0) ? 1 : field. Maximum 7 pops per turn with WW=3.
- Pop condition (cycle): state=SERVE & sched_en & !vc_empty[grant_vc] & credit!=0 & !dest_almost_full.
  - The registered pipeline allows at most one outstanding pop.
  - dest_almost_full must assert with at least 1 entry of slack; destination TOL>=1 is required.
- States:
  - IDLE:
    - vc_rd=0.
    - If sched_en & any !vc_empty: select the first non-empty VC searching from (grant_vc+1) mod 4 round-robin (from 0 after reset), load credit=w_eff of that VC, go SERVE. Transition takes 1 cycle; no pop in the transition cycle.
  - SERVE:
    - When the pop condition holds: vc_rd[grant_vc]=1, credit-=1.
    - Go to ROTATE when, after this cycle, credit==0, or vc_empty[grant_vc]=1 with no pop this cycle.
    - Stay in SERVE while stalled by dest_almost_full or sched_en=0; credit is kept.
  - ROTATE:
    - vc_rd=0.
    - Search the next non-empty VC from (grant_vc+1) mod 4 (wraps 3->0). The current VC is last in the search order, so it is re-granted only if it is the sole non-empty VC.
    - If found: update grant_vc, reload credit, go SERVE.
    - If none: go IDLE, grant_vc unchanged.
- Simultaneous events:
  - vc_empty rising in the same cycle as the pop that emptied the FIFO: pop is legal; rotate next cycle.
  - sched_en falling mid-turn: the pending write still completes; no further pops; grant and credit are held.
- Error: if dest_wr=1 while dest_full=1:
  - The write is still issued.
  - sched_error sets and stays 1 until reset.
- Throughput: one word per cycle in SERVE with no stalls. Each VC switch costs 1 ROTATE bubble.

Test Plan:
- Reset mid-pop: assert vc_rd[0], drop reset_L before the next edge -> dest_wr=0, all outputs 0 immediately, sched_error=0.
- Equal weights: weights all 1, VC0..VC3 each preloaded with 2 words (VC0: 0x01,0x02; VC1: 0x11,0x12; ...) -> destination order 01,11,21,31,02,12,22,32, each VC switch separated by one bubble.
- Weighted: weights VC0=3, VC1=1, VC2=0, VC3=0, all FIFOs holding 8 words -> grant pattern 0,0,0,1,2,3 repeating; VC2 and VC3 get 1 pop each per round (weight 0 treated as 1).
- Backpressure: raise dest_almost_full for 5 cycles mid-turn with credit=2 -> no vc_rd during the stall, credit stays 2, the outstanding write still lands, and the turn resumes with 2 pops.
- Empty skip and wrap: only VC3 and VC1 non-empty, grant_vc=3 -> next grant is VC1 (wraps past 0); when both are empty -> IDLE with grant_vc=1.
- Overflow flag: hold dest_full=1 with dest_almost_full forced 0 while a write lands -> sched_error=1, and it stays 1 after dest_full clears until reset_L=0.
